// File: rtl/decode_queue.sv
// Decode stage: decodes each instruction at enqueue and holds DEPTH decoded bundles in a FIFO between IF and EX.
// Head outputs are registered (1-cycle enqueue-to-head latency); in_ready drops when full or flushing.
module decode_queue #(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 1,
  parameter int ALU_OP_W = 33
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [4:0]              rd,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  output logic [XLEN-1:0]         imm,
  output logic                    need_imm,
  output logic [ALU_OP_W-1:0]     alu_op,
  output logic                    reg_wen,
  output logic                    mem_wen,
  output logic                    is_load,
  output logic                    is_branch,
  output logic                    is_jal,
  output logic                    is_jalr,
  output logic                    is_auipc,
  output logic                    is_ebreak,
  output logic [3:0]              wdt_op,
  output logic                    is_unsigned,
  output logic                    illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  localparam int A_ADD = 0,  A_SUB = 1,  A_SLL = 2,  A_SLT = 3,  A_SLTU = 4,  A_XOR = 5;
  localparam int A_SRL = 6,  A_SRA = 7,  A_OR = 8,   A_AND = 9,  A_ADDW = 10, A_SUBW = 11;
  localparam int A_SLLW = 12, A_SRLW = 13, A_SRAW = 14, A_EQ = 15, A_NE = 16, A_GE = 17;
  localparam int A_GEU = 18, A_MUL = 19, A_MULH = 20, A_MULHSU = 21, A_MULHU = 22, A_DIV = 23;
  localparam int A_DIVU = 24, A_REM = 25, A_REMU = 26, A_MULW = 27, A_DIVW = 28, A_DIVUW = 29;
  localparam int A_REMW = 30, A_REMUW = 31, A_LUI = 32;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OP_IMM = 7'b0010011, OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011, OPC_OP_32 = 7'b0111011, OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN-1:0]     imm;
    logic                need_imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_wen;
    logic                mem_wen;
    logic                is_load;
    logic                is_branch;
    logic                is_jal;
    logic                is_jalr;
    logic                is_auipc;
    logic                is_ebreak;
    logic [3:0]          wdt_op;
    logic                is_unsigned;
    logic                illegal;
  } entry_t;

  function automatic logic [ALU_OP_W-1:0] oh(input int idx);
    oh = ALU_OP_W'(1) << idx;
  endfunction

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w;
  logic sh_ok, legal;
  entry_t dec, clr, head;

  assign opc     = in_inst[6:0];
  assign f3      = in_inst[14:12];
  assign f7      = in_inst[31:25];
  assign imm_i32 = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u32 = {in_inst[31:12], 12'b0};
  assign imm_j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_i   = XLEN'(imm_i32);
  assign imm_s   = XLEN'(imm_s32);
  assign imm_b   = XLEN'(imm_b32);
  assign imm_u   = XLEN'(imm_u32);
  assign imm_j   = XLEN'(imm_j32);
  assign shamt   = XLEN'(in_inst[20 +: SHW]);
  assign shamt_w = XLEN'(in_inst[24:20]);
  // On RV32 inst[25] belongs to funct7, so a set bit is not a valid shift amount.
  assign sh_ok   = (XLEN == 64) || !in_inst[25];

  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    dec.pc    = in_pc;
    dec.rd    = in_inst[11:7];
    dec.rs1   = in_inst[19:15];
    dec.rs2   = in_inst[24:20];
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; dec.reg_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_u; dec.alu_op = oh(A_LUI);
      end
      OPC_AUIPC: begin
        legal = 1'b1; dec.reg_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_u; dec.alu_op = oh(A_ADD);
        dec.is_auipc = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; dec.reg_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_j; dec.alu_op = oh(A_ADD);
        dec.is_jal = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); dec.reg_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_i;
        dec.alu_op = oh(A_ADD); dec.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        legal = 1'b1; dec.imm = imm_b; dec.is_branch = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = oh(A_EQ);
          3'b001:  dec.alu_op = oh(A_NE);
          3'b100:  dec.alu_op = oh(A_SLT);
          3'b101:  dec.alu_op = oh(A_GE);
          3'b110:  dec.alu_op = oh(A_SLTU);
          3'b111:  dec.alu_op = oh(A_GEU);
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = 1'b1; dec.reg_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_i;
        dec.alu_op = oh(A_ADD); dec.is_load = 1'b1;
        case (f3)
          3'b000:  dec.wdt_op = 4'b0001;
          3'b001:  dec.wdt_op = 4'b0010;
          3'b010:  dec.wdt_op = 4'b0100;
          3'b011:  begin dec.wdt_op = 4'b1000; legal = (XLEN == 64); end
          3'b100:  begin dec.wdt_op = 4'b0001; dec.is_unsigned = 1'b1; end
          3'b101:  begin dec.wdt_op = 4'b0010; dec.is_unsigned = 1'b1; end
          3'b110:  begin dec.wdt_op = 4'b0100; dec.is_unsigned = 1'b1; legal = (XLEN == 64); end
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        legal = 1'b1; dec.mem_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_s; dec.alu_op = oh(A_ADD);
        case (f3)
          3'b000:  dec.wdt_op = 4'b0001;
          3'b001:  dec.wdt_op = 4'b0010;
          3'b010:  dec.wdt_op = 4'b0100;
          3'b011:  begin dec.wdt_op = 4'b1000; legal = (XLEN == 64); end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = 1'b1; dec.reg_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_i;
        case (f3)
          3'b000: dec.alu_op = oh(A_ADD);
          3'b010: dec.alu_op = oh(A_SLT);
          3'b011: dec.alu_op = oh(A_SLTU);
          3'b100: dec.alu_op = oh(A_XOR);
          3'b110: dec.alu_op = oh(A_OR);
          3'b111: dec.alu_op = oh(A_AND);
          3'b001: begin
            dec.imm = shamt; dec.alu_op = oh(A_SLL);
            legal = sh_ok && (in_inst[31:26] == 6'b000000);
          end
          default: begin
            dec.imm = shamt;
            dec.alu_op = in_inst[30] ? oh(A_SRA) : oh(A_SRL);
            legal = sh_ok && (in_inst[31:26] == 6'b000000 || in_inst[31:26] == 6'b010000);
          end
        endcase
      end
      OPC_OP: begin
        legal = 1'b1; dec.reg_wen = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  dec.alu_op = oh(A_ADD);
              3'b001:  dec.alu_op = oh(A_SLL);
              3'b010:  dec.alu_op = oh(A_SLT);
              3'b011:  dec.alu_op = oh(A_SLTU);
              3'b100:  dec.alu_op = oh(A_XOR);
              3'b101:  dec.alu_op = oh(A_SRL);
              3'b110:  dec.alu_op = oh(A_OR);
              default: dec.alu_op = oh(A_AND);
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      dec.alu_op = oh(A_SUB);
            else if (f3 == 3'b101) dec.alu_op = oh(A_SRA);
            else                   legal = 1'b0;
          end
          7'b0000001: begin
            legal = (ENABLE_M != 0);
            case (f3)
              3'b000:  dec.alu_op = oh(A_MUL);
              3'b001:  dec.alu_op = oh(A_MULH);
              3'b010:  dec.alu_op = oh(A_MULHSU);
              3'b011:  dec.alu_op = oh(A_MULHU);
              3'b100:  dec.alu_op = oh(A_DIV);
              3'b101:  dec.alu_op = oh(A_DIVU);
              3'b110:  dec.alu_op = oh(A_REM);
              default: dec.alu_op = oh(A_REMU);
            endcase
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        legal = (XLEN == 64); dec.reg_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = shamt_w;
        case (f3)
          3'b000: begin dec.imm = imm_i; dec.alu_op = oh(A_ADDW); end
          3'b001: begin dec.alu_op = oh(A_SLLW); legal = legal && (f7 == 7'b0000000); end
          3'b101: begin
            dec.alu_op = in_inst[30] ? oh(A_SRAW) : oh(A_SRLW);
            legal = legal && (f7 == 7'b0000000 || f7 == 7'b0100000);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        legal = (XLEN == 64); dec.reg_wen = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: dec.alu_op = oh(A_ADDW);
          {7'b0000000, 3'b001}: dec.alu_op = oh(A_SLLW);
          {7'b0000000, 3'b101}: dec.alu_op = oh(A_SRLW);
          {7'b0100000, 3'b000}: dec.alu_op = oh(A_SUBW);
          {7'b0100000, 3'b101}: dec.alu_op = oh(A_SRAW);
          {7'b0000001, 3'b000}: begin dec.alu_op = oh(A_MULW);  legal = legal && (ENABLE_M != 0); end
          {7'b0000001, 3'b100}: begin dec.alu_op = oh(A_DIVW);  legal = legal && (ENABLE_M != 0); end
          {7'b0000001, 3'b101}: begin dec.alu_op = oh(A_DIVUW); legal = legal && (ENABLE_M != 0); end
          {7'b0000001, 3'b110}: begin dec.alu_op = oh(A_REMW);  legal = legal && (ENABLE_M != 0); end
          {7'b0000001, 3'b111}: begin dec.alu_op = oh(A_REMUW); legal = legal && (ENABLE_M != 0); end
          default:              legal = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        legal = (in_inst == 32'h0010_0073);
        dec.is_ebreak = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries keep only pc and register ids so EX can raise the exception with no side effects.
  always_comb begin
    clr         = '0;
    clr.pc      = dec.pc;
    clr.rd      = dec.rd;
    clr.rs1     = dec.rs1;
    clr.rs2     = dec.rs2;
    clr.illegal = 1'b1;
  end

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign in_ready  = (count_q != CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= legal ? dec : clr;
  end

  assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_pc      = head.pc;
  assign rd          = head.rd;
  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign imm         = head.imm;
  assign need_imm    = head.need_imm;
  assign alu_op      = head.alu_op;
  assign reg_wen     = head.reg_wen;
  assign mem_wen     = head.mem_wen;
  assign is_load     = head.is_load;
  assign is_branch   = head.is_branch;
  assign is_jal      = head.is_jal;
  assign is_jalr     = head.is_jalr;
  assign is_auipc    = head.is_auipc;
  assign is_ebreak   = head.is_ebreak;
  assign wdt_op      = head.wdt_op;
  assign is_unsigned = head.is_unsigned;
  assign illegal     = head.illegal;
  assign count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: an RV64+M instance (a) and an RV32 no-M instance (b) share all inputs.
module tb_decode_queue;

  localparam int B_ADD = 0, B_SLL = 2, B_ADDW = 10, B_EQ = 15, B_MUL = 19, B_LUI = 32;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst;
  logic [63:0] pc64;
  logic [31:0] pc32;
  assign pc32 = pc64[31:0];

  logic        a_in_ready, a_out_valid, a_need_imm, a_reg_wen, a_mem_wen, a_is_load, a_is_branch;
  logic        a_is_jal, a_is_jalr, a_is_auipc, a_is_ebreak, a_is_unsigned, a_illegal;
  logic [63:0] a_out_pc, a_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [32:0] a_alu_op;
  logic [3:0]  a_wdt_op;
  logic [1:0]  a_count;

  logic        b_in_ready, b_out_valid, b_need_imm, b_reg_wen, b_mem_wen, b_is_load, b_is_branch;
  logic        b_is_jal, b_is_jalr, b_is_auipc, b_is_ebreak, b_is_unsigned, b_illegal;
  logic [31:0] b_out_pc, b_imm;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [32:0] b_alu_op;
  logic [3:0]  b_wdt_op;
  logic [1:0]  b_count;

  decode_queue #(.XLEN(64), .DEPTH(2), .ENABLE_M(1), .ALU_OP_W(33)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
    .in_pc(pc64), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm), .need_imm(a_need_imm),
    .alu_op(a_alu_op), .reg_wen(a_reg_wen), .mem_wen(a_mem_wen), .is_load(a_is_load),
    .is_branch(a_is_branch), .is_jal(a_is_jal), .is_jalr(a_is_jalr), .is_auipc(a_is_auipc),
    .is_ebreak(a_is_ebreak), .wdt_op(a_wdt_op), .is_unsigned(a_is_unsigned),
    .illegal(a_illegal), .count(a_count));

  decode_queue #(.XLEN(32), .DEPTH(2), .ENABLE_M(0), .ALU_OP_W(33)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc(pc32), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .imm(b_imm), .need_imm(b_need_imm),
    .alu_op(b_alu_op), .reg_wen(b_reg_wen), .mem_wen(b_mem_wen), .is_load(b_is_load),
    .is_branch(b_is_branch), .is_jal(b_is_jal), .is_jalr(b_is_jalr), .is_auipc(b_is_auipc),
    .is_ebreak(b_is_ebreak), .wdt_op(b_wdt_op), .is_unsigned(b_is_unsigned),
    .illegal(b_illegal), .count(b_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ohx(input int idx);
    ohx = (idx < 0) ? 64'd0 : (64'd1 << idx);
  endfunction

  // flags = {is_branch, is_load, mem_wen, is_ebreak}
  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        ill_a, wen_a;
    logic [63:0] imm_a;
    int          alu_a;
    logic [3:0]  wdt_a, flg_a;
    logic        ill_b, wen_b;
    logic [63:0] imm_b;
    int          alu_b;
    logic [3:0]  wdt_b, flg_b;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'h00500093, 5'd1,  1'b0, 1'b1, 64'd5, B_ADD, 4'h0, 4'h0,
                                     1'b0, 1'b1, 64'd5, B_ADD, 4'h0, 4'h0};
    vecs[1] = '{32'hFE000EE3, 5'd29, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, B_EQ, 4'h0, 4'b1000,
                                     1'b0, 1'b0, 64'h00000000FFFFFFFC, B_EQ, 4'h0, 4'b1000};
    vecs[2] = '{32'h0010009B, 5'd1,  1'b0, 1'b1, 64'd1, B_ADDW, 4'h0, 4'h0,
                                     1'b1, 1'b0, 64'd0, -1, 4'h0, 4'h0};
    vecs[3] = '{32'h022081B3, 5'd3,  1'b0, 1'b1, 64'd0, B_MUL, 4'h0, 4'h0,
                                     1'b1, 1'b0, 64'd0, -1, 4'h0, 4'h0};
    vecs[4] = '{32'h00000000, 5'd0,  1'b1, 1'b0, 64'd0, -1, 4'h0, 4'h0,
                                     1'b1, 1'b0, 64'd0, -1, 4'h0, 4'h0};
    vecs[5] = '{32'h02011093, 5'd1,  1'b0, 1'b1, 64'd32, B_SLL, 4'h0, 4'h0,
                                     1'b1, 1'b0, 64'd0, -1, 4'h0, 4'h0};
    vecs[6] = '{32'h800002B7, 5'd5,  1'b0, 1'b1, 64'hFFFFFFFF80000000, B_LUI, 4'h0, 4'h0,
                                     1'b0, 1'b1, 64'h0000000080000000, B_LUI, 4'h0, 4'h0};
    vecs[7] = '{32'h00813083, 5'd1,  1'b0, 1'b1, 64'd8, B_ADD, 4'b1000, 4'b0100,
                                     1'b1, 1'b0, 64'd0, -1, 4'h0, 4'h0};
    vecs[8] = '{32'hFE20AE23, 5'd28, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, B_ADD, 4'b0100, 4'b0010,
                                     1'b0, 1'b0, 64'h00000000FFFFFFFC, B_ADD, 4'b0100, 4'b0010};
    vecs[9] = '{32'h00100073, 5'd0,  1'b0, 1'b0, 64'd0, -1, 4'h0, 4'b0001,
                                     1'b0, 1'b0, 64'd0, -1, 4'h0, 4'b0001};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; pc64 = 64'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_alu_op", 64'(a_alu_op), 64'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_inst = vecs[i].inst; pc64 = 64'h80000000 + 64'(i * 4); in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; #1;
      chk($sformatf("v%0d_a_count", i), 64'(a_count), 64'd1);
      chk($sformatf("v%0d_a_valid", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("v%0d_a_pc", i), a_out_pc, 64'h80000000 + 64'(i * 4));
      chk($sformatf("v%0d_a_rd", i), 64'(a_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_a_illegal", i), 64'(a_illegal), 64'(vecs[i].ill_a));
      chk($sformatf("v%0d_a_reg_wen", i), 64'(a_reg_wen), 64'(vecs[i].wen_a));
      chk($sformatf("v%0d_a_imm", i), a_imm, vecs[i].imm_a);
      chk($sformatf("v%0d_a_alu_op", i), 64'(a_alu_op), ohx(vecs[i].alu_a));
      chk($sformatf("v%0d_a_wdt_op", i), 64'(a_wdt_op), 64'(vecs[i].wdt_a));
      chk($sformatf("v%0d_a_flags", i), 64'({a_is_branch, a_is_load, a_mem_wen, a_is_ebreak}),
          64'(vecs[i].flg_a));
      chk($sformatf("v%0d_b_pc", i), 64'(b_out_pc), 64'h80000000 + 64'(i * 4));
      chk($sformatf("v%0d_b_rd", i), 64'(b_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_b_illegal", i), 64'(b_illegal), 64'(vecs[i].ill_b));
      chk($sformatf("v%0d_b_reg_wen", i), 64'(b_reg_wen), 64'(vecs[i].wen_b));
      chk($sformatf("v%0d_b_imm", i), 64'(b_imm), vecs[i].imm_b);
      chk($sformatf("v%0d_b_alu_op", i), 64'(b_alu_op), ohx(vecs[i].alu_b));
      chk($sformatf("v%0d_b_wdt_op", i), 64'(b_wdt_op), 64'(vecs[i].wdt_b));
      chk($sformatf("v%0d_b_flags", i), 64'({b_is_branch, b_is_load, b_mem_wen, b_is_ebreak}),
          64'(vecs[i].flg_b));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    #1;
    chk("drain_count", 64'(a_count), 64'd0);

    // Backpressure: three back-to-back offers into a 2-deep queue with EX stalled.
    @(negedge clk);
    in_inst = 32'h00500093; in_valid = 1'b1; pc64 = 64'h100; #1;
    chk("bp_ready0", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    pc64 = 64'h104; #1;
    chk("bp_count1", 64'(a_count), 64'd1);
    @(negedge clk);
    pc64 = 64'h108; #1;
    chk("bp_full_ready", 64'(a_in_ready), 64'd0);
    chk("bp_full_count", 64'(a_count), 64'd2);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("bp_third_dropped", 64'(a_count), 64'd2);
    chk("bp_head0", a_out_pc, 64'h100);
    @(negedge clk); #1;
    chk("bp_head1", a_out_pc, 64'h104);
    chk("bp_ready_after_pop", 64'(a_in_ready), 64'd1);
    chk("bp_count_after_pop", 64'(a_count), 64'd1);
    @(negedge clk); #1;
    chk("bp_empty_valid", 64'(a_out_valid), 64'd0);
    chk("bp_empty_count", 64'(a_count), 64'd0);

    // Simultaneous push/pop at count 1, then flush with an offer pending.
    out_ready = 1'b0; in_valid = 1'b1; pc64 = 64'h200;
    @(negedge clk);
    pc64 = 64'h204; out_ready = 1'b1; #1;
    chk("pp_count_before", 64'(a_count), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("pp_count_after", 64'(a_count), 64'd1);
    chk("pp_head", a_out_pc, 64'h204);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; pc64 = 64'h208; #1;
    chk("fl_in_ready", 64'(a_in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("fl_count", 64'(a_count), 64'd0);
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_pc", a_out_pc, 64'd0);
    chk("fl_rd", 64'(a_rd), 64'd0);
    chk("fl_reg_wen", 64'(a_reg_wen), 64'd0);
    chk("fl_alu_op", 64'(a_alu_op), 64'd0);
    chk("fl_b_count", 64'(b_count), 64'd0);

    // Reset while full.
    in_valid = 1'b1; pc64 = 64'h300;
    @(negedge clk);
    pc64 = 64'h304;
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("rs_full_count", 64'(a_count), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rs_count", 64'(a_count), 64'd0);
    chk("rs_valid", 64'(a_out_valid), 64'd0);
    chk("rs_in_ready", 64'(a_in_ready), 64'd1);
    chk("rs_b_count", 64'(b_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised instruction-decode stage with a DEPTH-entry decoded-instruction queue and valid/ready handshakes on both sides. Sits between IF and EX. Each instruction is decoded combinationally at enqueue, and the full decoded bundle is stored in the queue. Generalises the existing decode path with XLEN selection (RV32/RV64), an optional M extension, strict illegal-instruction detection, backpressure and flush.

Parameters:
XLEN, 64, datapath width; 32 or 64 only. Sets pc/imm width and RV64-only legality.
DEPTH, 2, queue entries; power of two, at least 2.
ENABLE_M, 1, when 1 the M-extension ops are legal; when 0 they decode as illegal.
ALU_OP_W, 33, width of the one-hot project Aluop vector (existing bit assignments unchanged).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IF offers an instruction
in_ready  out  1  queue can accept
in_inst  in  32  raw instruction
in_pc  in  XLEN  instruction pc
flush  in  1  discard all queued entries
out_valid  out  1  head entry valid
out_ready  in  1  EX consumes head
out_pc  out  XLEN  head pc
rd, rs1, rs2  out  5 each  register ids
imm  out  XLEN  sign-extended immediate, selected per I/S/B/U/J format; 0 for R-type
need_imm  out  1  second ALU operand is imm
alu_op  out  ALU_OP_W  one-hot ALU operation
reg_wen, mem_wen, is_load, is_branch, is_jal, is_jalr, is_auipc, is_ebreak  out  1 each
wdt_op  out  4  one-hot access width {64,32,16,8}
is_unsigned  out  1  lbu/lhu/lwu
illegal  out  1  unsupported encoding
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Push when in_valid & in_ready. Pop when out_valid & out_ready. in_ready = (count != DEPTH) & ~flush; there is no bypass when full.
- Latency: an instruction pushed in cycle N appears at the head in cycle N+1 if the queue was empty. Order is strictly FIFO. Head outputs come straight from storage (registered).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged. Read and write pointers wrap modulo DEPTH.
- flush: next cycle count = 0 and out_valid = 0. The same-cycle input is not accepted (in_ready = 0). flush overrides a same-cycle pop.
- When out_valid = 0, every decoded output, out_pc and illegal read 0.
- Reset: count = 0, pointers = 0, out_valid = 0, in_ready = 1 the cycle after rst deasserts. Reset mid-operation discards all entries.
- Decode covers the RV32I ALU/imm/branch/jump/load/store/lui/auipc/ebreak group, the RV64I *W ops and ld/sd/lwu, and M (mul..remuw). Aluop and wdt_op mapping is the project-standard one.
- Immediates: sign-extended from the top instruction bit to XLEN. U-type is imm[31:12]<<12, then sign-extended.
- illegal = 1 for:
  - any encoding not in the supported set, including inst == 0;
  - XLEN=32 with OP_IMM_32, OP_32, ld, sd, lwu, or slli/srli/srai with inst[25] = 1;
  - ENABLE_M=0 with any funct7 = 0000001 op in OP or OP_32.
- An illegal entry carries reg_wen = mem_wen = 0, alu_op = 0, all is_* = 0, wdt_op = 0, but valid rd/rs1/rs2/pc. It is still queued and handed to EX (the exception is raised downstream).
- Shifts: shamt is inst[25:20] for XLEN=64 and inst[24:20] for XLEN=32. Shift immediates are passed through imm.

Test Plan:
- XLEN=64: push 0x00500093 (addi x1,x0,5) at pc 0x80000000 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, need_imm=1, reg_wen=1, AluopAdd set, illegal=0, count=1.
- DEPTH=2, out_ready=0: push 3 back-to-back -> in_ready=0 after 2 pushes, count=2, third not taken. Then out_ready=1 -> pcs emerge in push order, in_ready=1 after first pop.
- Count=1, simultaneous push and pop -> count stays 1, new head = pushed pc. Flush with in_valid=1 -> in_ready=0 that cycle, next cycle count=0, out_valid=0, all outputs 0.
- Push 0xFE000EE3 (beq x0,x0,-4) with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC, is_branch=1, AluopEq, reg_wen=0. With XLEN=32 -> imm=0xFFFFFFFC.
- XLEN=32: push 0x0010009B (addiw) -> illegal=1, reg_wen=0, alu_op=0. With XLEN=64 -> legal, AluopAddw, reg_wen=1.
- ENABLE_M=0: push 0x022081B3 (mul x3,x1,x2) -> illegal=1, rd=3. ENABLE_M=1 -> AluopMul, reg_wen=1. Push 0x00000000 -> illegal=1.
- Assert rst while count=2 -> next cycle count=0, out_valid=0, in_ready=1.
